// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of the two master ports, the shared slave port and the grant
// vector of the MMIO bus arbiter.
// The slave modport is the arbiter's own view. The master modport is the
// view of the surrounding logic: the masters, the peripheral and any
// observer of grant.
interface mmio_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m0_rdata;
    logic          m0_done;
    logic          m0_err;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] m1_rdata;
    logic          m1_done;
    logic          m1_err;

    logic          s_req;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic          s_ack;

    logic [1:0]    grant;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_done, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_rdata, m1_done, m1_err,
        output s_req, s_we, s_addr, s_wdata,
        input  s_rdata, s_ack,
        output grant
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_done, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_rdata, m1_done, m1_err,
        input  s_req, s_we, s_addr, s_wdata,
        output s_rdata, s_ack,
        input  grant
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-master / one-slave MMIO bus arbiter.
// Uses round-robin grant and runs one transaction at a time.
// Each transaction has a timeout; on expiry the transaction completes
// with an error flag.
// All outputs come straight from flops.
module mmio_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic      clk,
    input  logic      rst,
    mmio_bus_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 0 = M0, 1 = M1
    logic          last_q,  last_d;    // most recent owner to complete
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          s_req_q, s_req_d;
    logic          s_we_q,  s_we_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [1:0]    grant_q, grant_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic          m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic          m0_err_q,  m0_err_d,  m1_err_q,  m1_err_d;

    logic          win_s;
    logic          fin_s;
    logic          fin_err_s;
    logic [DW-1:0] fin_rdata_s;
    logic [DW-1:0] owner_rdata_s;

    // Next-state logic: arbitration, transaction latching, timeout and completion.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        s_req_d     = s_req_q;
        s_we_d      = s_we_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        grant_d     = grant_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_done_d   = 1'b0;
        m0_err_d    = 1'b0;
        m1_done_d   = 1'b0;
        m1_err_d    = 1'b0;
        win_s       = 1'b0;
        fin_s       = 1'b0;
        fin_err_s   = 1'b0;
        fin_rdata_s = {DW{1'b0}};
        owner_rdata_s = owner_q ? m1_rdata_q : m0_rdata_q;

        case (state_q)
            IDLE: begin
                s_req_d = 1'b0;
                grant_d = 2'b00;
                // On a tie the master that did not finish last wins.
                if (bus.m0_req && bus.m1_req) begin
                    win_s = ~last_q;
                end else begin
                    win_s = bus.m1_req;
                end
                if (bus.m0_req || bus.m1_req) begin
                    owner_d   = win_s;
                    s_we_d    = win_s ? bus.m1_we    : bus.m0_we;
                    s_addr_d  = win_s ? bus.m1_addr  : bus.m0_addr;
                    s_wdata_d = win_s ? bus.m1_wdata : bus.m0_wdata;
                    grant_d   = win_s ? 2'b10 : 2'b01;
                    cnt_d     = {CW{1'b0}};
                    s_req_d   = 1'b1;
                    state_d   = BUS;
                end else begin
                    state_d   = IDLE;
                end
            end
            BUS: begin
                // An ack on the timeout edge still counts as a clean completion.
                if (bus.s_ack) begin
                    fin_s       = 1'b1;
                    fin_err_s   = 1'b0;
                    fin_rdata_s = s_we_q ? owner_rdata_s : bus.s_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    fin_s       = 1'b1;
                    fin_err_s   = 1'b1;
                    fin_rdata_s = {DW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (fin_s) begin
                    s_req_d = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                last_d  = owner_q;
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                s_req_d = 1'b0;
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase

        // Route the completion to the owning master only.
        if (fin_s && !owner_q) begin
            m0_done_d  = 1'b1;
            m0_err_d   = fin_err_s;
            m0_rdata_d = fin_rdata_s;
        end else if (fin_s && owner_q) begin
            m1_done_d  = 1'b1;
            m1_err_d   = fin_err_s;
            m1_rdata_d = fin_rdata_s;
        end else begin
            m0_done_d  = 1'b0;
            m1_done_d  = 1'b0;
        end
    end

    // State and output registers; reset clears everything and favours M0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= {CW{1'b0}};
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= {AW{1'b0}};
            s_wdata_q  <= {DW{1'b0}};
            grant_q    <= 2'b00;
            m0_rdata_q <= {DW{1'b0}};
            m1_rdata_q <= {DW{1'b0}};
            m0_done_q  <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_done_q  <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            grant_q    <= grant_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_done_q  <= m0_done_d;
            m0_err_q   <= m0_err_d;
            m1_done_q  <= m1_done_d;
            m1_err_q   <= m1_err_d;
        end
    end

    assign bus.s_req    = s_req_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.grant    = grant_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m0_done  = m0_done_q;
    assign bus.m0_err   = m0_err_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.m1_err   = m1_err_q;
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: directed scenarios plus a
// randomized transaction-level run against a round-robin reference model.
`timescale 1ns/1ps
module tb_mmio_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mmio_bus_if #(.AW(AW), .DW(DW)) bus ();

    mmio_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.s_ack = 1'b0;  bus.s_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_req(input int m, input logic r, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (m == 0) begin
            bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = wd;
        end
    endtask

    function automatic logic [1:0] onehot(input int m);
        return (m == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic test_reset();
        logic [2*DW+AW+DW+8-1:0] outs;
        rst = 1'b1;
        clear_inputs();
        step(); step();
        outs = {bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.grant,
                bus.m0_done, bus.m0_err, bus.m0_rdata, bus.m1_done, bus.m1_err, bus.m1_rdata};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst = 1'b0;
        step();
        // Complete a read so that m0_rdata is non-zero before the mid-BUS reset.
        drive_req(0, 1'b1, 1'b0, 32'h4000_0040, 32'h0);
        step();
        bus.s_ack = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({bus.m0_done, bus.m0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL reset_pre_read: got %b/%h want 1/deadbeef", bus.m0_done, bus.m0_rdata);
        end
        drive_req(0, 1'b0, 1'b0, 32'h4000_0040, 32'h0);
        bus.s_ack = 1'b0;
        step();
        drive_req(1, 1'b1, 1'b1, 32'h4000_0044, 32'h0000_0055);
        step(); step();
        checks++;
        if ({bus.s_req, bus.grant} !== 3'b1_10) begin
            failures++; $display("FAIL reset_pre_bus: got %b%b want 110", bus.s_req, bus.grant);
        end
        #1 rst = 1'b1;
        #1;
        outs = {bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata, bus.grant,
                bus.m0_done, bus.m0_err, bus.m0_rdata, bus.m1_done, bus.m1_err, bus.m1_rdata};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_mid_bus: got %h want 0", outs); end
        clear_inputs();
        step();
        rst = 1'b0;
        step(); step();
        checks++;
        if ({bus.s_req, bus.grant, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err} !== 7'b0) begin
            failures++; $display("FAIL reset_after_release: got %b%b%b%b want 0", bus.s_req, bus.grant, bus.m0_done, bus.m1_done);
        end
        drive_req(0, 1'b1, 1'b0, 32'h4000_0048, 32'h0);
        step();
        checks++;
        if ({bus.s_req, bus.grant, bus.s_addr} !== {1'b1, 2'b01, 32'h4000_0048}) begin
            failures++; $display("FAIL reset_idle_restart: got %b %b %h want 1 01 40000048", bus.s_req, bus.grant, bus.s_addr);
        end
        bus.s_ack = 1'b1; bus.s_rdata = 32'h0;
        step();
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.s_ack = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        drive_req(0, 1'b1, 1'b0, 32'h4000_0010, 32'h0);
        step();
        checks++;
        if ({bus.s_req, bus.grant, bus.s_we, bus.s_addr} !== {1'b1, 2'b01, 1'b0, 32'h4000_0010}) begin
            failures++; $display("FAIL read_bus: got %b %b %b %h want 1 01 0 40000010", bus.s_req, bus.grant, bus.s_we, bus.s_addr);
        end
        bus.s_ack = 1'b1; bus.s_rdata = 32'h1234_5678;
        step();
        checks++;
        if ({bus.m0_done, bus.m0_err, bus.m0_rdata, bus.grant, bus.s_req, bus.m1_done} !==
            {1'b1, 1'b0, 32'h1234_5678, 2'b01, 1'b0, 1'b0}) begin
            failures++; $display("FAIL read_resp: got done=%b err=%b rdata=%h grant=%b s_req=%b want 1 0 12345678 01 0",
                                 bus.m0_done, bus.m0_err, bus.m0_rdata, bus.grant, bus.s_req);
        end
        drive_req(0, 1'b0, 1'b0, 32'h4000_0010, 32'h0);
        bus.s_ack = 1'b0; bus.s_rdata = 32'h0;
        step();
        checks++;
        if ({bus.m0_done, bus.grant, bus.m0_rdata} !== {1'b0, 2'b00, 32'h1234_5678}) begin
            failures++; $display("FAIL read_idle: got done=%b grant=%b rdata=%h want 0 00 12345678", bus.m0_done, bus.grant, bus.m0_rdata);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] a[2];
        int owner;
        a[0] = 32'h4000_0100;
        a[1] = 32'h4000_0200;
        do_reset();
        drive_req(0, 1'b1, 1'b0, a[0], 32'h0);
        drive_req(1, 1'b1, 1'b0, a[1], 32'h0);
        for (int i = 0; i < 4; i++) begin
            owner = i % 2;
            step();
            checks++;
            if ({bus.s_req, bus.grant, bus.s_addr} !== {1'b1, onehot(owner), a[owner]}) begin
                failures++; $display("FAIL contention_grant[%0d]: got %b %b %h want 1 %b %h",
                                     i, bus.s_req, bus.grant, bus.s_addr, onehot(owner), a[owner]);
            end
            bus.s_ack = 1'b1; bus.s_rdata = 32'h0000_1000 + i;
            step();
            checks++;
            if ({bus.m0_done, bus.m1_done} !== ((owner == 1) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL contention_done[%0d]: got m0=%b m1=%b want owner M%0d", i, bus.m0_done, bus.m1_done, owner);
            end
            drive_req(owner, 1'b0, 1'b0, a[owner], 32'h0);
            bus.s_ack = 1'b0;
            step();
            if (i < 2) drive_req(owner, 1'b1, 1'b0, a[owner], 32'h0);
        end
    endtask

    task automatic test_timeout();
        drive_req(1, 1'b1, 1'b1, 32'h4000_0004, 32'hA5A5_A5A5);
        step();
        for (int k = 1; k <= TIMEOUT; k++) begin
            checks++;
            if ({bus.s_req, bus.s_we, bus.s_wdata, bus.m1_done} !== {1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0}) begin
                failures++; $display("FAIL timeout_bus[%0d]: got s_req=%b we=%b wdata=%h done=%b want 1 1 a5a5a5a5 0",
                                     k, bus.s_req, bus.s_we, bus.s_wdata, bus.m1_done);
            end
            step();
        end
        checks++;
        if ({bus.m1_done, bus.m1_err, bus.m1_rdata, bus.grant} !== {1'b1, 1'b1, 32'h0, 2'b10}) begin
            failures++; $display("FAIL timeout_resp: got done=%b err=%b rdata=%h grant=%b want 1 1 0 10",
                                 bus.m1_done, bus.m1_err, bus.m1_rdata, bus.grant);
        end
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_ack_on_timeout_edge();
        drive_req(0, 1'b1, 1'b0, 32'h4000_0030, 32'h0);
        step();
        for (int k = 1; k <= TIMEOUT; k++) begin
            bus.s_ack = (k == TIMEOUT);
            bus.s_rdata = (k == TIMEOUT) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
            step();
            if (k < TIMEOUT) begin
                checks++;
                if (bus.m0_done !== 1'b0) begin failures++; $display("FAIL late_ack_early_done[%0d]: got 1 want 0", k); end
            end
        end
        checks++;
        if ({bus.m0_done, bus.m0_err, bus.m0_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            failures++; $display("FAIL late_ack_resp: got done=%b err=%b rdata=%h want 1 0 cafef00d", bus.m0_done, bus.m0_err, bus.m0_rdata);
        end
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.s_ack = 1'b0;
        step();
    endtask

    task automatic test_latched_inputs();
        drive_req(0, 1'b1, 1'b0, 32'h4000_0020, 32'h0);
        step();
        drive_req(0, 1'b1, 1'b1, 32'h4FFF_FFF0, 32'h7777_7777);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({bus.s_req, bus.s_we, bus.s_addr, bus.s_wdata} !== {1'b1, 1'b0, 32'h4000_0020, 32'h0}) begin
                failures++; $display("FAIL latched_bus[%0d]: got we=%b addr=%h wdata=%h want 0 40000020 0", k, bus.s_we, bus.s_addr, bus.s_wdata);
            end
        end
        bus.s_ack = 1'b1; bus.s_rdata = 32'h1111_2222;
        step();
        drive_req(0, 1'b0, 1'b0, 32'h4000_0020, 32'h0);
        bus.s_ack = 1'b0;
        step();
        bus.s_ack = 1'b1; bus.s_rdata = 32'h9999_9999;
        step(); step();
        checks++;
        if ({bus.s_req, bus.grant, bus.m0_done, bus.m1_done, bus.m0_rdata} !== {5'b0, 32'h1111_2222}) begin
            failures++; $display("FAIL spurious_ack: got s_req=%b grant=%b d0=%b d1=%b rdata=%h want 0 00 0 0 11112222",
                                 bus.s_req, bus.grant, bus.m0_done, bus.m1_done, bus.m0_rdata);
        end
        bus.s_ack = 1'b0;
        step();
    endtask

    // Transaction-level model: pending flags, round-robin tie rule, per-master read data.
    task automatic test_random();
        logic          pend[2];
        logic          we[2];
        logic [AW-1:0] addr[2];
        logic [DW-1:0] wdata[2];
        logic [DW-1:0] exp_rd[2];
        logic [DW-1:0] ack_rd;
        logic [DW-1:0] rd;
        logic          exp_err;
        int            last_m, win, d, n;
        do_reset();
        last_m = 1;
        for (int m = 0; m < 2; m++) begin pend[m] = 1'b0; exp_rd[m] = '0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0; end
        for (int t = 0; t < 40; t++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && ($urandom_range(0, 2) != 0)) begin
                    pend[m] = 1'b1;
                    we[m] = 1'($urandom_range(0, 1));
                    addr[m] = {4'h4, 28'($urandom)};
                    wdata[m] = $urandom;
                    drive_req(m, 1'b1, we[m], addr[m], wdata[m]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[t % 2] = 1'b1; we[t % 2] = 1'b0; addr[t % 2] = {4'h4, 28'($urandom)}; wdata[t % 2] = $urandom;
                drive_req(t % 2, 1'b1, we[t % 2], addr[t % 2], wdata[t % 2]);
            end
            bus.s_ack = 1'($urandom_range(0, 1));
            bus.s_rdata = $urandom;
            win = (pend[0] && pend[1]) ? (1 - last_m) : (pend[1] ? 1 : 0);
            step();
            checks++;
            if ({bus.s_req, bus.grant, bus.s_we, bus.s_addr, bus.s_wdata} !== {1'b1, onehot(win), we[win], addr[win], wdata[win]}) begin
                failures++; $display("FAIL rand_start[%0d]: got s_req=%b grant=%b we=%b addr=%h wdata=%h want 1 %b %b %h %h",
                                     t, bus.s_req, bus.grant, bus.s_we, bus.s_addr, bus.s_wdata, onehot(win), we[win], addr[win], wdata[win]);
            end
            d = $urandom_range(1, TIMEOUT + 3);
            n = (d <= TIMEOUT) ? d : TIMEOUT;
            ack_rd = '0;
            for (int k = 1; k <= n; k++) begin
                rd = $urandom;
                bus.s_ack = (k == d);
                bus.s_rdata = rd;
                if (k == d) ack_rd = rd;
                step();
                if (k < n) begin
                    checks++;
                    if ({bus.s_req, bus.m0_done, bus.m1_done} !== 3'b100) begin
                        failures++; $display("FAIL rand_wait[%0d.%0d]: got s_req=%b d0=%b d1=%b want 1 0 0", t, k, bus.s_req, bus.m0_done, bus.m1_done);
                    end
                end
            end
            exp_err = (d > TIMEOUT);
            exp_rd[win] = exp_err ? '0 : (we[win] ? exp_rd[win] : ack_rd);
            checks++;
            if ({bus.s_req, bus.grant, bus.m0_done, bus.m1_done, (win == 1) ? bus.m1_err : bus.m0_err, bus.m0_rdata, bus.m1_rdata} !==
                {1'b0, onehot(win), (win == 0), (win == 1), exp_err, exp_rd[0], exp_rd[1]}) begin
                failures++; $display("FAIL rand_done[%0d]: got s_req=%b grant=%b d=%b%b err=%b/%b rd=%h/%h want win M%0d err=%b rd=%h/%h",
                                     t, bus.s_req, bus.grant, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
                                     bus.m0_rdata, bus.m1_rdata, win, exp_err, exp_rd[0], exp_rd[1]);
            end
            pend[win] = 1'b0;
            drive_req(win, 1'b0, we[win], addr[win], wdata[win]);
            last_m = win;
            bus.s_ack = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({bus.s_req, bus.grant, bus.m0_done, bus.m1_done} !== 5'b0) begin
                failures++; $display("FAIL rand_idle[%0d]: got s_req=%b grant=%b d=%b%b want 0", t, bus.s_req, bus.grant, bus.m0_done, bus.m1_done);
            end
            if (!pend[0] && !pend[1] && ($urandom_range(0, 1) == 1)) begin
                bus.s_ack = 1'($urandom_range(0, 1));
                step();
                checks++;
                if ({bus.s_req, bus.grant} !== 3'b0) begin
                    failures++; $display("FAIL rand_gap[%0d]: got s_req=%b grant=%b want 0", t, bus.s_req, bus.grant);
                end
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_ack_on_timeout_edge();
        test_latched_inputs();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
